// File: rtl/freq_gen_pkg.sv
// Shared definitions for the programmable frequency generator blocks.
// Holds the output-mode encoding, the default counter width and a small mode helper.
// Pure declarations; no logic and no timing of its own.
package freq_gen_pkg;

    // Default width of divisor and phase counter
    localparam int CNT_W_DEF = 24;

    // Output mode encoding
    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    // True when the given mode drives the square output
    function automatic logic mode_is_square(input logic mode);
        return (mode == MODE_SQUARE);
    endfunction

endpackage

// File: rtl/div_cfg_shadow.sv
// Divisor/mode configuration: shadow register, pending flag, zero-divisor rejection.
// Load to div_pend is one cycle; the active value changes on the cycle after an apply request.
// Never stalls the loader: a new load overwrites the shadow, last write wins.
module div_cfg_shadow
    import freq_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_div_load,
    input  logic [CNT_W-1:0] i_div_in,
    input  logic             i_mode_in,
    input  logic             i_apply_req,
    output logic [CNT_W-1:0] o_active_div,
    output logic             o_active_mode,
    output logic             o_shadow_mode,
    output logic             o_apply,
    output logic             o_div_pend,
    output logic             o_div_err
);

    logic [CNT_W-1:0] r_shadow_div;
    logic             r_shadow_mode;
    logic [CNT_W-1:0] r_active_div;
    logic             r_active_mode;
    logic             r_pend;
    logic             r_err;

    logic             w_load_ok;
    logic             w_load_zero;
    logic             w_apply;

    // A zero divisor would never reach terminal count, so it is refused outright
    assign w_load_zero = i_div_load & (i_div_in == '0);
    assign w_load_ok   = i_div_load & (i_div_in != '0);

    // Only a value that was already pending before this cycle may be applied;
    // a load arriving together with the apply request waits for the next one.
    assign w_apply     = i_apply_req & r_pend;

    // Shadow capture of the requested divisor and mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow_div  <= CNT_W'(DEFAULT_DIV);
            r_shadow_mode <= MODE_SQUARE;
        end else if (w_load_ok) begin
            r_shadow_div  <= i_div_in;
            r_shadow_mode <= i_mode_in;
        end
    end

    // Active configuration, updated only at an apply point
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active_div  <= CNT_W'(DEFAULT_DIV);
            r_active_mode <= MODE_SQUARE;
        end else if (w_apply) begin
            r_active_div  <= r_shadow_div;
            r_active_mode <= r_shadow_mode;
        end
    end

    // Pending flag: a fresh load keeps it set even when an older value is applied now
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (w_load_ok) begin
            r_pend <= 1'b1;
        end else if (w_apply) begin
            r_pend <= 1'b0;
        end
    end

    // One-cycle error pulse for a rejected zero divisor
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_load_zero;
        end
    end

    assign o_active_div  = r_active_div;
    assign o_active_mode = r_active_mode;
    assign o_shadow_mode = r_shadow_mode;
    assign o_apply       = w_apply;
    assign o_div_pend    = r_pend;
    assign o_div_err     = r_err;

endmodule

// File: rtl/prog_freq_divider.sv
// Runtime-programmable divider producing a square wave and a one-cycle terminal-count tick.
// tick/q are registered: they change on the clock after the terminal count.
// No backpressure; ena=0 freezes the phase, loads are accepted at any time.
module prog_freq_divider
    import freq_gen_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             sync_clr,
    input  logic [CNT_W-1:0] div_in,
    input  logic             mode_in,
    input  logic             div_load,
    output logic             q,
    output logic             tick,
    output logic             div_pend,
    output logic             div_err
);

    logic [CNT_W-1:0] r_cnt;
    logic             r_q;
    logic             r_tick;

    logic [CNT_W-1:0] w_active_div;
    logic             w_active_mode;
    logic             w_shadow_mode;
    logic             w_apply;
    logic             w_tc;
    logic             w_apply_req;
    logic             w_mode_change;
    logic             w_q_next;

    // Terminal count; active divisor is never zero so the subtraction cannot wrap
    assign w_tc = (r_cnt == (w_active_div - CNT_W'(1)));

    // Pending configuration is taken at an enabled terminal count or at a phase clear
    assign w_apply_req = sync_clr | (ena & w_tc);

    // A mode switch at apply restarts the square output from low
    assign w_mode_change = w_apply & (w_shadow_mode != w_active_mode);

    // Square output toggles at terminal count; pulse mode keeps it low
    assign w_q_next = w_mode_change ? 1'b0 :
                      (mode_is_square(w_active_mode) ? ~r_q : 1'b0);

    div_cfg_shadow #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_cfg (
        .clk           (clk),
        .rst           (rst),
        .i_div_load    (div_load),
        .i_div_in      (div_in),
        .i_mode_in     (mode_in),
        .i_apply_req   (w_apply_req),
        .o_active_div  (w_active_div),
        .o_active_mode (w_active_mode),
        .o_shadow_mode (w_shadow_mode),
        .o_apply       (w_apply),
        .o_div_pend    (div_pend),
        .o_div_err     (div_err)
    );

    // Phase counter, square output and tick; clear beats enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_tick <= 1'b0;
        end else if (sync_clr) begin
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_tick <= 1'b0;
        end else if (ena) begin
            if (w_tc) begin
                r_cnt  <= '0;
                r_q    <= w_q_next;
                r_tick <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign q    = r_q;
    assign tick = r_tick;

endmodule

// File: tb/tb_prog_freq_divider.sv
module tb_prog_freq_divider;

    localparam int CW   = 24;
    localparam int DDIV = 10;

    logic          clk;
    logic          rst;
    logic          ena;
    logic          sync_clr;
    logic [CW-1:0] div_in;
    logic          mode_in;
    logic          div_load;
    logic          q;
    logic          tick;
    logic          div_pend;
    logic          div_err;

    int checks   = 0;
    int failures = 0;

    // Reference model state, described by the behavioural rules of the divider
    int m_cnt;
    int m_n;
    bit m_square;
    bit m_q;
    bit m_tick;
    bit m_pend;
    bit m_err;
    int m_sdiv;
    bit m_ssquare;

    prog_freq_divider #(.CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .sync_clr (sync_clr),
        .div_in   (div_in),
        .mode_in  (mode_in),
        .div_load (div_load),
        .q        (q),
        .tick     (tick),
        .div_pend (div_pend),
        .div_err  (div_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_n = DDIV; m_square = 1'b1; m_q = 1'b0; m_tick = 1'b0;
        m_pend = 1'b0; m_err = 1'b0; m_sdiv = DDIV; m_ssquare = 1'b1;
    endtask

    // One enabled/disabled clock of the divider, in terms of periods and apply points
    task automatic model_step(input bit e, input bit c, input bit l, input int d, input bit m);
        bit accept;
        accept = l && (d != 0);
        if (c) begin
            m_cnt = 0; m_q = 1'b0; m_tick = 1'b0;
            if (m_pend) begin
                m_n = m_sdiv; m_square = m_ssquare; m_pend = 1'b0;
            end
        end else if (e) begin
            if (m_cnt + 1 == m_n) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                if (m_pend && (m_ssquare != m_square)) m_q = 1'b0;
                else m_q = m_square ? !m_q : 1'b0;
                if (m_pend) begin
                    m_n = m_sdiv; m_square = m_ssquare; m_pend = 1'b0;
                end
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        if (accept) begin
            m_sdiv = d; m_ssquare = !m; m_pend = 1'b1;
        end
        m_err = l && (d == 0);
    endtask

    task automatic compare_all();
        chk("q", {31'd0, q}, {31'd0, m_q});
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("div_pend", {31'd0, div_pend}, {31'd0, m_pend});
        chk("div_err", {31'd0, div_err}, {31'd0, m_err});
    endtask

    // Called at a falling edge: drive, clock once, compare at the next falling edge
    task automatic step(input bit e, input bit c, input bit l, input int d, input bit m);
        ena = e; sync_clr = c; div_load = l; div_in = CW'(d); mode_in = m;
        model_step(e, c, l, d, m);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    // Enabled idle cycles until tick is seen; n=-1 if the bound expires
    task automatic run_until_tick(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 1'b0);
            if (tick === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic async_reset(input string tag);
        #3;
        rst = 1'b1; ena = 1'b0; sync_clr = 1'b0; div_load = 1'b0; div_in = '0; mode_in = 1'b0;
        #1;
        model_reset();
        chk({tag, "_q"}, {31'd0, q}, 32'd0);
        chk({tag, "_tick"}, {31'd0, tick}, 32'd0);
        chk({tag, "_pend"}, {31'd0, div_pend}, 32'd0);
        chk({tag, "_err"}, {31'd0, div_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int  n;
        bit  qs;
        rst = 1'b1; ena = 1'b0; sync_clr = 1'b0; div_load = 1'b0; div_in = '0; mode_in = 1'b0;
        model_reset();
        #3;
        chk("reset_q", {31'd0, q}, 32'd0);
        chk("reset_tick", {31'd0, tick}, 32'd0);
        chk("reset_pend", {31'd0, div_pend}, 32'd0);
        chk("reset_err", {31'd0, div_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: default divisor, first tick after 10 enabled cycles, then every 10
        run_until_tick(30, n);
        chk("t1_first_tick", n, 10);
        chk("t1_q_after_first", {31'd0, q}, 32'd1);
        run_until_tick(30, n);
        chk("t1_period", n, 10);
        chk("t1_q_after_second", {31'd0, q}, 32'd0);

        // 2: load N=3 at cnt=5, pending until the old terminal count
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 3, 1'b0);
        chk("t2_pend_set", {31'd0, div_pend}, 32'd1);
        run_until_tick(30, n);
        chk("t2_old_tc", n, 4);
        chk("t2_pend_clear", {31'd0, div_pend}, 32'd0);
        run_until_tick(30, n);
        chk("t2_new_period", n, 3);

        // 3: zero divisor rejected
        step(1'b1, 1'b0, 1'b1, 0, 1'b0);
        chk("t3_err", {31'd0, div_err}, 32'd1);
        chk("t3_pend", {31'd0, div_pend}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        chk("t3_err_gone", {31'd0, div_err}, 32'd0);
        run_until_tick(30, n);
        run_until_tick(30, n);
        chk("t3_period_kept", n, 3);

        // 4: N=1 in pulse mode, tick every enabled cycle, q low
        step(1'b1, 1'b0, 1'b1, 1, 1'b1);
        run_until_tick(30, n);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 0, 1'b0);
            chk("t4_tick", {31'd0, tick}, 32'd1);
            chk("t4_q", {31'd0, q}, 32'd0);
        end

        // 5: back to N=10 square, then freeze at cnt=4
        step(1'b1, 1'b0, 1'b1, 10, 1'b0);
        run_until_tick(30, n);
        run_until_tick(30, n);
        chk("t5_period10", n, 10);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
        qs = q;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b0, 1'b0, 0, 1'b0);
            chk("t5_frozen_tick", {31'd0, tick}, 32'd0);
            chk("t5_frozen_q", {31'd0, q}, {31'd0, qs});
        end
        run_until_tick(30, n);
        chk("t5_resume", n, 6);

        // 6: load N=5 then sync_clr applies it at once
        step(1'b1, 1'b0, 1'b1, 5, 1'b0);
        step(1'b1, 1'b1, 1'b0, 0, 1'b0);
        chk("t6_q", {31'd0, q}, 32'd0);
        chk("t6_pend", {31'd0, div_pend}, 32'd0);
        run_until_tick(30, n);
        chk("t6_first_tick", n, 5);

        // 7: async reset with a pending load discards it
        step(1'b1, 1'b0, 1'b1, 3, 1'b0);
        async_reset("t7");
        run_until_tick(30, n);
        chk("t7_default_period", n, 10);

        // Randomized traffic against the model
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 99) < 85,
                     $urandom_range(0, 99) < 3,
                     $urandom_range(0, 99) < 8,
                     int'($urandom_range(0, 6)),
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
